// File: rtl/ucsbece154a_fetch_pkg.sv
// ucsbece154a_fetch_pkg
//   Shared definitions for the instruction-fetch stage and its helpers:
//   fetch state encodings, the NOP word that sits on instr_o out of reset,
//   and the default reset PC.
package ucsbece154a_fetch_pkg;

  // 2-bit fetch state encoding. ST_DROP is only reachable when the
  // FETCH_PREFETCH_EN build option is enabled.
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DROP  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/ucsbece154a_pc_next.sv
// ucsbece154a_pc_next
//   Combinational next-PC logic shared by fetch and the datapath.
//   Ports:
//     pc_i        current PC
//     pcsrc_i     1 = take target, 0 = fall through
//     target_i    branch/jump target (low two bits are forced to zero)
//     pcplus4_o   pc_i + 4, wrapping modulo 2^XLEN
//     pc_next_o   selected next PC, always word aligned
//     misalign_o  taken target had non-zero bits [1:0]
module ucsbece154a_pc_next #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic            pcsrc_i,
  input  logic [XLEN-1:0] target_i,
  output logic [XLEN-1:0] pcplus4_o,
  output logic [XLEN-1:0] pc_next_o,
  output logic            misalign_o
);

  assign pcplus4_o  = pc_i + XLEN'(4);
  assign pc_next_o  = pcsrc_i ? {target_i[XLEN-1:2], 2'b00} : pcplus4_o;
  assign misalign_o = pcsrc_i & (target_i[1:0] != 2'b00);

endmodule

// File: rtl/ucsbece154a_fetch.sv
// ucsbece154a_fetch
//   Instruction-fetch stage: owns the PC, fetches words from a variable
//   latency instruction memory and hands each instruction to decode once.
//   Ports:
//     clk, reset_n        clock, asynchronous active-low reset
//     imem_req_o/addr_o   request toward instruction memory (addr word aligned)
//     imem_ack_i/rdata_i  memory response; rdata valid only with ack
//     instr_valid_o/ready_i, instr_o, pc_o, pcplus4_o   decode handshake
//     PCSrc_i, PCTarget_i next-PC select/target, sampled only on accept
//     misalign_o          sticky: a taken target had bits [1:0] != 0
//     dbg_state_o         current fetch state (fetch_state_e encoding)
//   Build option: FETCH_PREFETCH_EN adds a one-entry prefetch of PC+4
//   during HOLD and the DROP state that discards a stale prefetch.
//
//   Handshakes: a transfer happens on a rising edge where valid (or req)
//   and ready (or ack) are both 1. While valid/req is 1 and no transfer
//   has happened, the producer keeps the payload stable.
import ucsbece154a_fetch_pkg::*;

module ucsbece154a_fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pcplus4_o,
  input  logic            PCSrc_i,
  input  logic [XLEN-1:0] PCTarget_i,
  output logic            misalign_o,
  output logic [1:0]      dbg_state_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] pc_next;
  logic            tgt_mis;
  logic            req;
  logic [XLEN-1:0] addr;

`ifdef FETCH_PREFETCH_EN
  logic            pf_valid_q, pf_valid_d;
  logic [XLEN-1:0] pf_data_q, pf_data_d;
  logic [XLEN-1:0] pf_addr_q, pf_addr_d;   // address of the prefetch in flight/held
`endif

  ucsbece154a_pc_next #(.XLEN(XLEN)) u_pc_next (
    .pc_i       (pc_q),
    .pcsrc_i    (PCSrc_i),
    .target_i   (PCTarget_i),
    .pcplus4_o  (pcplus4_o),
    .pc_next_o  (pc_next),
    .misalign_o (tgt_mis)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    mis_d   = mis_q;
    req     = 1'b0;
    addr    = pc_q;
`ifdef FETCH_PREFETCH_EN
    pf_valid_d = pf_valid_q;
    pf_data_d  = pf_data_q;
    pf_addr_d  = pf_addr_q;
`endif
    case (state_q)
      ST_FETCH: begin
        req = 1'b1;
        if (imem_ack_i) begin
          instr_d = imem_rdata_i;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
`ifdef FETCH_PREFETCH_EN
        // Keep asking for PC+4 until it lands in the buffer.
        req  = ~pf_valid_q;
        addr = pcplus4_o;
        if (imem_ack_i && !pf_valid_q) begin
          pf_valid_d = 1'b1;
          pf_data_d  = imem_rdata_i;
          pf_addr_d  = pcplus4_o;
        end
`endif
        if (instr_ready_i) begin
          pc_d    = pc_next;
          mis_d   = mis_q | tgt_mis;
          state_d = ST_FETCH;
`ifdef FETCH_PREFETCH_EN
          pf_valid_d = 1'b0;
          if (!PCSrc_i) begin
            if (pf_valid_q) begin
              instr_d = pf_data_q;
              state_d = ST_HOLD;
            end else if (imem_ack_i) begin
              instr_d = imem_rdata_i;
              state_d = ST_HOLD;
            end
            // Otherwise FETCH keeps waiting on the same request: new PC == old PC+4.
          end else if (!pf_valid_q && !imem_ack_i) begin
            pf_addr_d = pcplus4_o;
            state_d   = ST_DROP;
          end
`endif
        end
      end
`ifdef FETCH_PREFETCH_EN
      ST_DROP: begin
        // Hold the stale request until memory answers, then throw the data away.
        req  = 1'b1;
        addr = pf_addr_q;
        if (imem_ack_i) state_d = ST_FETCH;
      end
`endif
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= XLEN'(NOP_INSTR);
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      mis_q   <= mis_d;
    end
  end

`ifdef FETCH_PREFETCH_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pf_valid_q <= 1'b0;
      pf_data_q  <= '0;
      pf_addr_q  <= '0;
    end else begin
      pf_valid_q <= pf_valid_d;
      pf_data_q  <= pf_data_d;
      pf_addr_q  <= pf_addr_d;
    end
  end
`endif

  // Reset forces FETCH, so the request is gated by reset_n to read 0 during
  // reset and rise straight away on release (an ack in that first cycle is
  // the response for RESET_PC).
  assign imem_req_o    = req & reset_n;
  assign imem_addr_o   = {addr[XLEN-1:2], 2'b00};
  assign instr_valid_o = (state_q == ST_HOLD);
  assign instr_o       = instr_q;
  assign pc_o          = pc_q;
  assign misalign_o    = mis_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_ucsbece154a_fetch.sv
module tb_ucsbece154a_fetch;
  import ucsbece154a_fetch_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic         imem_req_o, imem_ack_i, instr_valid_o, instr_ready_i;
  logic         PCSrc_i, misalign_o;
  logic [W-1:0] imem_addr_o, imem_rdata_i, instr_o, pc_o, pcplus4_o, PCTarget_i;
  logic [1:0]   dbg_state_o;

  ucsbece154a_fetch dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pcplus4_o     (pcplus4_o),
    .PCSrc_i       (PCSrc_i),
    .PCTarget_i    (PCTarget_i),
    .misalign_o    (misalign_o),
    .dbg_state_o   (dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  logic [2*W-1:0] exp_q[$];   // {pc, instr} per fetched word, oldest first
  int total = 0;
  int bad   = 0;

  task automatic chk32(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  // Memory contents: a fixed function of the word address.
  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0013_5A00;
  endfunction

  // ---------------- driver ----------------
  // Entered at posedge+1 with the DUT expected to be in FETCH for pc.
  // Memory acks after lat cycles, decode stalls for stall cycles, then accepts.
  task automatic run_vec(input logic [W-1:0] pc, input int lat, input int stall,
                         input logic pcsrc, input logic [W-1:0] tgt, input logic mis);
    int n;
    logic [2*W-1:0] e;
    n = 0;
    while (!imem_req_o && n < 16) begin
      @(posedge clk); #1;
      n++;
    end
    chk1("req_raised", imem_req_o, 1'b1);
    chk32("fetch_addr", imem_addr_o, pc);
    chk1("no_valid_in_fetch", instr_valid_o, 1'b0);
    for (int i = 1; i < lat; i++) begin
      imem_rdata_i = $urandom;
      @(posedge clk); #1;
      chk32("addr_stable", imem_addr_o, pc);
      chk1("req_held", imem_req_o, 1'b1);
      chk1("no_early_valid", instr_valid_o, 1'b0);
    end
    imem_ack_i   = 1'b1;
    imem_rdata_i = mem_word(pc);
    exp_q.push_back({pc, mem_word(pc)});
    @(posedge clk); #1;
    imem_ack_i   = 1'b0;
    imem_rdata_i = $urandom;
    chk1("valid_after_ack", instr_valid_o, 1'b1);
    chk1("no_req_in_hold", imem_req_o, 1'b0);
    chk32("state_hold", {30'd0, dbg_state_o}, {30'd0, ST_HOLD});
    for (int i = 0; i < stall; i++) begin
      // Stray acks and random PCSrc/target while stalled must have no effect.
      instr_ready_i = 1'b0;
      imem_ack_i    = 1'($urandom_range(0, 1));
      imem_rdata_i  = $urandom;
      PCSrc_i       = 1'($urandom_range(0, 1));
      PCTarget_i    = $urandom;
      @(posedge clk); #1;
      chk1("stall_valid", instr_valid_o, 1'b1);
      chk1("stall_no_req", imem_req_o, 1'b0);
      chk32("stall_instr", instr_o, exp_q[0][W-1:0]);
      chk32("stall_pc", pc_o, exp_q[0][2*W-1:W]);
    end
    imem_ack_i    = 1'b0;
    PCSrc_i       = pcsrc;
    PCTarget_i    = tgt;
    instr_ready_i = 1'b1;
    e = exp_q.pop_front();
    chk32("pc_o", pc_o, e[2*W-1:W]);
    chk32("instr_o", instr_o, e[W-1:0]);
    chk32("pcplus4_o", pcplus4_o, e[2*W-1:W] + 32'd4);
    @(posedge clk); #1;
    instr_ready_i = 1'b0;
    PCSrc_i       = 1'b0;
    PCTarget_i    = $urandom;
    chk1("valid_drop_after_accept", instr_valid_o, 1'b0);
    chk1("misalign", misalign_o, mis);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [W-1:0] pc;
    int           lat;
    int           stall;
    logic         pcsrc;
    logic [W-1:0] tgt;
    logic         mis;   // misalign_o expected after this accept
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [W-1:0] pc_m;

    vecs[0] = '{32'h0000_0000, 1, 0, 1'b0, 32'h0,         1'b0};
    vecs[1] = '{32'h0000_0004, 1, 0, 1'b0, 32'h0,         1'b0};
    vecs[2] = '{32'h0000_0008, 3, 4, 1'b0, 32'h0,         1'b0};
    vecs[3] = '{32'h0000_000C, 2, 1, 1'b0, 32'h0,         1'b0};
    vecs[4] = '{32'h0000_0010, 1, 0, 1'b1, 32'h0000_0040, 1'b0};
    vecs[5] = '{32'h0000_0040, 1, 0, 1'b0, 32'h0,         1'b0};
    vecs[6] = '{32'h0000_0044, 2, 0, 1'b1, 32'h0000_0042, 1'b1};
    vecs[7] = '{32'h0000_0040, 1, 2, 1'b1, 32'hFFFF_FFFC, 1'b1};
    vecs[8] = '{32'hFFFF_FFFC, 1, 0, 1'b0, 32'h0,         1'b1};
    vecs[9] = '{32'h0000_0000, 1, 1, 1'b0, 32'h0,         1'b1};

    imem_ack_i    = 1'b0;
    imem_rdata_i  = '0;
    instr_ready_i = 1'b0;
    PCSrc_i       = 1'b0;
    PCTarget_i    = '0;

    // Reset state while reset_n is held low.
    #12;
    chk1("rst_req", imem_req_o, 1'b0);
    chk1("rst_valid", instr_valid_o, 1'b0);
    chk1("rst_misalign", misalign_o, 1'b0);
    chk32("rst_instr_nop", instr_o, 32'h0000_0013);
    chk32("rst_pc", pc_o, 32'h0);
    chk32("rst_state", {30'd0, dbg_state_o}, {30'd0, ST_FETCH});
    @(posedge clk); #1;
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run_vec(vecs[i].pc, vecs[i].lat, vecs[i].stall, vecs[i].pcsrc, vecs[i].tgt, vecs[i].mis);

    // Random latency/stall sequential stream continuing from 0x4.
    pc_m = 32'h4;
    for (int i = 0; i < 8; i++) begin
      run_vec(pc_m, $urandom_range(1, 4), $urandom_range(0, 3), 1'b0, 32'h0, 1'b1);
      pc_m = pc_m + 32'd4;
    end

    // Reset asserted while a request is outstanding.
    chk1("mid_req_up", imem_req_o, 1'b1);
    @(posedge clk); #1;
    chk32("mid_req_addr", imem_addr_o, pc_m);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk1("mid_rst_req_low", imem_req_o, 1'b0);
    chk1("mid_rst_valid_low", instr_valid_o, 1'b0);
    chk1("mid_rst_misalign_clr", misalign_o, 1'b0);
    chk32("mid_rst_pc", pc_o, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    // Ack in the very first cycle after release belongs to RESET_PC.
    run_vec(32'h0, 1, 0, 1'b0, 32'h0, 1'b0);

    // Reset asserted while an instruction is held for decode.
    chk32("hold_rst_addr", imem_addr_o, 32'h4);
    imem_ack_i   = 1'b1;
    imem_rdata_i = mem_word(32'h4);
    @(posedge clk); #1;
    imem_ack_i = 1'b0;
    chk1("hold_rst_valid_before", instr_valid_o, 1'b1);
    reset_n = 1'b0;
    #1;
    chk1("hold_rst_valid_low", instr_valid_o, 1'b0);
    chk1("hold_rst_req_low", imem_req_o, 1'b0);
    chk32("hold_rst_instr_nop", instr_o, 32'h0000_0013);
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_vec(32'h0, 2, 1, 1'b1, 32'h0000_0101, 1'b1);
    run_vec(32'h0000_0100, 1, 0, 1'b0, 32'h0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
